// File: rtl/td4_run_ctrl.sv
// Run controller for the TD4 CPU: 16x8 program store, host load port, run/step/pause/abort
// sequencing, self-jump halt detection and an instruction-budget timeout.
module td4_run_ctrl #(
    parameter logic [7:0] MAX_CYCLES = 8'd255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] cmd,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic [3:0] cpu_addr,
    output logic [7:0] cpu_data,
    output logic       cpu_ena,
    output logic       cpu_rst_n,
    output logic [2:0] state,
    output logic       halted,
    output logic       timeout,
    output logic [7:0] cycle_cnt
);

    localparam logic [2:0] ST_LOAD  = 3'd0;
    localparam logic [2:0] ST_PAUSE = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_STEP  = 3'd3;
    localparam logic [2:0] ST_HALT  = 3'd4;

    localparam logic [1:0] CMD_PAUSE = 2'b00;
    localparam logic [1:0] CMD_RUN   = 2'b01;
    localparam logic [1:0] CMD_STEP  = 2'b10;
    localparam logic [1:0] CMD_ABORT = 2'b11;

    logic [7:0] mem [16];

    logic [2:0] state_next;
    logic       halted_next;
    logic       timeout_next;
    logic [7:0] cnt_next;
    logic       take;
    logic       abort;
    logic       self_jump;
    logic       budget_hit;
    logic [8:0] cnt_inc;

    assign cpu_data  = mem[cpu_addr];
    assign cpu_ena   = (state == ST_RUN) || (state == ST_STEP);
    assign cpu_rst_n = (state != ST_LOAD);
    assign cmd_ready = (state != ST_STEP);

    assign take      = cmd_valid && cmd_ready;
    assign abort     = take && (cmd == CMD_ABORT);
    assign self_jump = cpu_ena && (cpu_data == {4'hF, cpu_addr});
    // 9-bit compare so a saturated counter never wraps into a false budget match
    assign cnt_inc    = {1'b0, cycle_cnt} + 9'd1;
    assign budget_hit = (MAX_CYCLES != 8'd0) && (state == ST_RUN)
                        && (cnt_inc == {1'b0, MAX_CYCLES});

    always_comb begin
        state_next   = state;
        halted_next  = halted;
        timeout_next = timeout;
        cnt_next     = cycle_cnt;

        if (cpu_ena && (cycle_cnt != 8'hFF)) begin
            cnt_next = cnt_inc[7:0];
        end

        if (abort) begin
            state_next   = ST_LOAD;
            halted_next  = 1'b0;
            timeout_next = 1'b0;
            cnt_next     = 8'd0;
        end else if (self_jump) begin
            state_next  = ST_HALT;
            halted_next = 1'b1;
        end else if (budget_hit) begin
            state_next   = ST_HALT;
            timeout_next = 1'b1;
        end else if (state == ST_STEP) begin
            state_next = ST_PAUSE;
        end else if (take) begin
            case (state)
                ST_LOAD, ST_PAUSE: begin
                    case (cmd)
                        CMD_RUN:   state_next = ST_RUN;
                        CMD_STEP:  state_next = ST_STEP;
                        CMD_PAUSE: state_next = ST_PAUSE;
                        default:   state_next = state;
                    endcase
                end
                ST_RUN: begin
                    if (cmd == CMD_PAUSE) begin
                        state_next = ST_PAUSE;
                    end
                end
                default: state_next = state;
            endcase
        end

        if ((state == ST_LOAD) && (state_next != ST_LOAD)) begin
            cnt_next = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_LOAD;
            halted    <= 1'b0;
            timeout   <= 1'b0;
            cycle_cnt <= 8'd0;
        end else begin
            state     <= state_next;
            halted    <= halted_next;
            timeout   <= timeout_next;
            cycle_cnt <= cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                mem[i] <= 8'h00;
            end
        end else if (wr_en && (state == ST_LOAD)) begin
            mem[wr_addr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_td4_run_ctrl.sv
// Self-checking bench for td4_run_ctrl: vector table through a scoreboard queue plus
// hand-written sequences for write gating, abort/halt race, reset mid-run and timeout.
module tb_td4_run_ctrl;

    localparam logic [2:0] S_LOAD = 3'd0, S_PAUSE = 3'd1, S_RUN = 3'd2, S_STEP = 3'd3,
                           S_HALT = 3'd4;
    localparam logic [1:0] C_PAUSE = 2'b00, C_RUN = 2'b01, C_STEP = 2'b10, C_ABORT = 2'b11;

    typedef struct packed {
        logic [2:0] st;
        logic       ena;
        logic       rdy;
        logic       rstn;
        logic       h;
        logic       t;
        logic [7:0] cnt;
    } exp_t;

    typedef struct packed {
        logic       r;
        logic [1:0] cmd;
        logic       v;
        logic       we;
        logic [3:0] wa;
        logic [7:0] wd;
        exp_t       e;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] cmd = 2'b00;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       wr_en = 1'b0;
    logic [3:0] wr_addr = 4'h0;
    logic [7:0] wr_data = 8'h00;
    logic [3:0] cpu_addr;
    logic [7:0] cpu_data;
    logic       cpu_ena;
    logic       cpu_rst_n;
    logic [2:0] state;
    logic       halted;
    logic       timeout;
    logic [7:0] cycle_cnt;

    logic [3:0] pc = 4'h0;
    logic       use_tb_addr = 1'b0;
    logic [3:0] tb_addr = 4'h0;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    vec_t tbl[15];

    td4_run_ctrl #(.MAX_CYCLES(8'd5)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd       (cmd),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .cpu_addr  (cpu_addr),
        .cpu_data  (cpu_data),
        .cpu_ena   (cpu_ena),
        .cpu_rst_n (cpu_rst_n),
        .state     (state),
        .halted    (halted),
        .timeout   (timeout),
        .cycle_cnt (cycle_cnt)
    );

    always #5 clk = ~clk;

    // Minimal TD4 PC: only JMP (op F) matters for control flow in these programs
    always @(posedge clk) begin
        if (rst || !cpu_rst_n) pc <= 4'h0;
        else if (cpu_ena) pc <= (cpu_data[7:4] == 4'hF) ? cpu_data[3:0] : pc + 4'h1;
    end
    assign cpu_addr = use_tb_addr ? tb_addr : pc;

    function automatic vec_t mk(input logic r, input logic [1:0] c, input logic v,
                                input logic we, input logic [3:0] wa, input logic [7:0] wd,
                                input logic [2:0] st, input logic ena, input logic rdy,
                                input logic rstn, input logic h, input logic t,
                                input logic [7:0] cnt);
        vec_t x;
        x.r = r; x.cmd = c; x.v = v; x.we = we; x.wa = wa; x.wd = wd;
        x.e.st = st; x.e.ena = ena; x.e.rdy = rdy; x.e.rstn = rstn;
        x.e.h = h; x.e.t = t; x.e.cnt = cnt;
        return x;
    endfunction

    task automatic chk(input string name, input int tag, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s #%0d: got %0h expected %0h", name, tag, act, exp);
        end
    endtask

    task automatic apply(input vec_t x, input int tag);
        exp_t e;
        rst = x.r; cmd = x.cmd; cmd_valid = x.v;
        wr_en = x.we; wr_addr = x.wa; wr_data = x.wd;
        sb.push_back(x.e);
        @(posedge clk);
        #1;
        rst = 1'b0; cmd_valid = 1'b0; wr_en = 1'b0;
        e = sb.pop_front();
        chk("state", tag, {5'b0, state}, {5'b0, e.st});
        chk("cpu_ena", tag, {7'b0, cpu_ena}, {7'b0, e.ena});
        chk("cmd_ready", tag, {7'b0, cmd_ready}, {7'b0, e.rdy});
        chk("cpu_rst_n", tag, {7'b0, cpu_rst_n}, {7'b0, e.rstn});
        chk("halted", tag, {7'b0, halted}, {7'b0, e.h});
        chk("timeout", tag, {7'b0, timeout}, {7'b0, e.t});
        chk("cycle_cnt", tag, cycle_cnt, e.cnt);
    endtask

    task automatic idle(input logic [2:0] st, input logic ena, input logic h, input logic t,
                        input logic [7:0] cnt, input int tag);
        apply(mk(1'b0, C_PAUSE, 1'b0, 1'b0, 4'h0, 8'h00, st, ena, st != S_STEP,
                 st != S_LOAD, h, t, cnt), tag);
    endtask

    task automatic go(input logic [1:0] c, input logic [2:0] st, input logic ena,
                      input logic h, input logic t, input logic [7:0] cnt, input int tag);
        apply(mk(1'b0, c, 1'b1, 1'b0, 4'h0, 8'h00, st, ena, st != S_STEP,
                 st != S_LOAD, h, t, cnt), tag);
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d, input int tag);
        apply(mk(1'b0, C_PAUSE, 1'b0, 1'b1, a, d, S_LOAD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                 8'd0), tag);
    endtask

    task automatic rd(input logic [3:0] a, input logic [7:0] exp, input int tag);
        use_tb_addr = 1'b1; tb_addr = a;
        #1;
        chk("mem_read", tag, cpu_data, exp);
        use_tb_addr = 1'b0;
    endtask

    initial begin
        // Reset, load a step-safe program, STEP twice, abort, reload for RUN-to-halt
        tbl[0]  = mk(1, C_PAUSE, 0, 0, 4'h0, 8'h00, S_LOAD,  0, 1, 0, 0, 0, 8'd0);
        tbl[1]  = mk(0, C_PAUSE, 0, 1, 4'h0, 8'h31, S_LOAD,  0, 1, 0, 0, 0, 8'd0);
        tbl[2]  = mk(0, C_PAUSE, 0, 1, 4'h1, 8'h32, S_LOAD,  0, 1, 0, 0, 0, 8'd0);
        tbl[3]  = mk(0, C_STEP,  1, 0, 4'h0, 8'h00, S_STEP,  1, 0, 1, 0, 0, 8'd0);
        tbl[4]  = mk(0, C_STEP,  1, 0, 4'h0, 8'h00, S_PAUSE, 0, 1, 1, 0, 0, 8'd1);
        tbl[5]  = mk(0, C_STEP,  1, 0, 4'h0, 8'h00, S_STEP,  1, 0, 1, 0, 0, 8'd1);
        tbl[6]  = mk(0, C_PAUSE, 0, 0, 4'h0, 8'h00, S_PAUSE, 0, 1, 1, 0, 0, 8'd2);
        tbl[7]  = mk(0, C_PAUSE, 1, 0, 4'h0, 8'h00, S_PAUSE, 0, 1, 1, 0, 0, 8'd2);
        tbl[8]  = mk(0, C_ABORT, 1, 0, 4'h0, 8'h00, S_LOAD,  0, 1, 0, 0, 0, 8'd0);
        tbl[9]  = mk(0, C_PAUSE, 0, 1, 4'h1, 8'hF1, S_LOAD,  0, 1, 0, 0, 0, 8'd0);
        tbl[10] = mk(0, C_RUN,   1, 0, 4'h0, 8'h00, S_RUN,   1, 1, 1, 0, 0, 8'd0);
        tbl[11] = mk(0, C_PAUSE, 0, 0, 4'h0, 8'h00, S_RUN,   1, 1, 1, 0, 0, 8'd1);
        tbl[12] = mk(0, C_PAUSE, 0, 1, 4'h3, 8'hAA, S_HALT,  0, 1, 1, 1, 0, 8'd2);
        tbl[13] = mk(0, C_RUN,   1, 0, 4'h0, 8'h00, S_HALT,  0, 1, 1, 1, 0, 8'd2);
        tbl[14] = mk(0, C_STEP,  1, 0, 4'h0, 8'h00, S_HALT,  0, 1, 1, 1, 0, 8'd2);

        @(posedge clk);
        #1;
        for (int i = 0; i < 15; i++) apply(tbl[i], i);

        // Write issued during RUN was dropped; program survives abort; write lands in LOAD
        rd(4'h3, 8'h00, 100);
        rd(4'h0, 8'h31, 101);
        go(C_ABORT, S_LOAD, 0, 0, 0, 8'd0, 102);
        rd(4'h1, 8'hF1, 103);
        use_tb_addr = 1'b1; tb_addr = 4'h3;
        wr_en = 1'b1; wr_addr = 4'h3; wr_data = 8'hAA;
        #1;
        chk("read_old_during_write", 104, cpu_data, 8'h00);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        chk("read_new_after_write", 105, cpu_data, 8'hAA);
        use_tb_addr = 1'b0;
        rd(4'h0, 8'h31, 106);

        // ABORT accepted in the very cycle a self-jump is visible
        go(C_RUN, S_RUN, 1, 0, 0, 8'd0, 110);
        idle(S_RUN, 1, 0, 0, 8'd1, 111);
        chk("selfjump_visible", 112, cpu_data, 8'hF1);
        go(C_ABORT, S_LOAD, 0, 0, 0, 8'd0, 113);

        // Synchronous reset in the middle of a run clears everything, memory included
        go(C_RUN, S_RUN, 1, 0, 0, 8'd0, 120);
        idle(S_RUN, 1, 0, 0, 8'd1, 121);
        apply(mk(1, C_PAUSE, 0, 0, 4'h0, 8'h00, S_LOAD, 0, 1, 0, 0, 0, 8'd0), 122);
        for (int a = 0; a < 16; a++) rd(a[3:0], 8'h00, 130 + a);

        // Budget of 5 with a 0x00/0xF0 loop that never self-jumps
        wr(4'h1, 8'hF0, 150);
        go(C_RUN, S_RUN, 1, 0, 0, 8'd0, 151);
        for (int k = 1; k <= 4; k++) idle(S_RUN, 1, 0, 0, k[7:0], 151 + k);
        idle(S_HALT, 0, 0, 1, 8'd5, 156);
        idle(S_HALT, 0, 0, 1, 8'd5, 157);

        // Self-jump and budget on the same edge: halt wins, timeout stays clear
        go(C_ABORT, S_LOAD, 0, 0, 0, 8'd0, 160);
        wr(4'h1, 8'h00, 161);
        wr(4'h4, 8'hF4, 162);
        go(C_RUN, S_RUN, 1, 0, 0, 8'd0, 163);
        for (int k = 1; k <= 4; k++) idle(S_RUN, 1, 0, 0, k[7:0], 163 + k);
        idle(S_HALT, 0, 1, 0, 8'd5, 168);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
